// File: rtl/icache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_pkg                                                       |
// | Shared constants, state encoding and address-field helpers.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package icache_pkg;

    localparam int ICACHE_MAX_WAYS = 2;

    typedef logic [1:0] state_t;
    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_REQ  = 2'd1;
    localparam state_t c_WAIT = 2'd2;
    localparam state_t c_FILL = 2'd3;

    function automatic int tag_bits(input int set_bits, input int word_bits);
        return 32 - set_bits - word_bits - 2;
    endfunction

    function automatic int line_words(input int word_bits);
        return 1 << word_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_way.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_way                                                       |
// | One way: tag, valid and data arrays with combinational lookup.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module icache_way
    import icache_pkg::*;
#(
    parameter int SET_BITS  = 4,
    parameter int WORD_BITS = 3,
    parameter int TAG_BITS  = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SET_BITS-1:0]  rd_set,
    input  logic [WORD_BITS-1:0] rd_word,
    input  logic [TAG_BITS-1:0]  rd_tag,
    output logic                 hit,
    output logic [31:0]          rdata,
    output logic                 set_valid,
    input  logic                 tag_we,
    input  logic [SET_BITS-1:0]  wr_set,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic                 data_we,
    input  logic [WORD_BITS-1:0] wr_word,
    input  logic [31:0]          wr_data,
    input  logic                 valid_we,
    input  logic                 inval_req,
    input  logic [SET_BITS-1:0]  inval_set,
    input  logic [TAG_BITS-1:0]  inval_tag,
    input  logic                 flush
);

    localparam int c_SETS  = 1 << SET_BITS;
    localparam int c_DEPTH = 1 << (SET_BITS + WORD_BITS);

    logic [TAG_BITS-1:0] r_tag  [0:c_SETS-1];
    logic [31:0]         r_data [0:c_DEPTH-1];
    logic [c_SETS-1:0]   r_valid;

    always_ff @(posedge clk) begin
        if (tag_we)
            r_tag[wr_set] <= wr_tag;
        if (data_we)
            r_data[{wr_set, wr_word}] <= wr_data;
    end

    // Later assignments win: an invalidate overrides a same-cycle fill completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (tag_we)
                r_valid[wr_set] <= 1'b0;
            if (valid_we)
                r_valid[wr_set] <= 1'b1;
            if (inval_req && (r_tag[inval_set] == inval_tag))
                r_valid[inval_set] <= 1'b0;
        end
    end

    assign set_valid = r_valid[rd_set];
    assign hit       = r_valid[rd_set] && (r_tag[rd_set] == rd_tag);
    assign rdata     = hit ? r_data[{rd_set, rd_word}] : 32'h0;

endmodule
`default_nettype wire

// File: rtl/l1_icache_assoc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | l1_icache_assoc                                                  |
// | 1/2-way L1 instruction cache with DCache peek and L2 burst fill. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module l1_icache_assoc
    import icache_pkg::*;
#(
    parameter int SET_BITS  = 4,
    parameter int WORD_BITS = 3,
    parameter int WAYS      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rreq,
    input  logic [31:0]          addr,
    output logic [31:0]          rdata,
    output logic                 miss,
    output logic                 l2_rreq,
    output logic [31:0]          l2_addr,
    output logic [4:0]           l2_burst_size,
    input  logic [31:0]          l2_rdata,
    input  logic                 l2_busy,
    output logic [31:0]          peek_addr,
    input  logic [31:0]          peek_rdata,
    input  logic                 peek_miss,
    input  logic                 invalid_req,
    input  logic [29-WORD_BITS:0] invalid_line,
    input  logic                 flush_req,
    output logic [31:0]          hit_count
);

    localparam int TAG_BITS     = tag_bits(SET_BITS, WORD_BITS);
    localparam int c_LINE_WORDS = line_words(WORD_BITS);
    localparam int c_OFF_BITS   = WORD_BITS + 2;
    localparam logic [WORD_BITS-1:0] c_LAST_WORD = '1;

    logic [TAG_BITS-1:0]  w_tag;
    logic [SET_BITS-1:0]  w_set;
    logic [WORD_BITS-1:0] w_word;
    logic [TAG_BITS-1:0]  w_inv_tag;
    logic [SET_BITS-1:0]  w_inv_set;
    logic                 w_unused_addr_bits;

    assign w_tag     = addr[31 -: TAG_BITS];
    assign w_set     = addr[c_OFF_BITS +: SET_BITS];
    assign w_word    = addr[2 +: WORD_BITS];
    assign w_inv_tag = invalid_line[SET_BITS +: TAG_BITS];
    assign w_inv_set = invalid_line[SET_BITS-1:0];
    assign w_unused_addr_bits = &{1'b0, addr[1:0]};

    state_t               r_state, w_next;
    logic [TAG_BITS-1:0]  r_fill_tag;
    logic [SET_BITS-1:0]  r_fill_set;
    logic                 r_victim;
    logic [WORD_BITS-1:0] r_word_cnt;
    logic                 r_kill;

    logic [WAYS-1:0]      w_way_hit;
    logic [WAYS-1:0]      w_way_valid;
    logic [31:0]          w_way_rdata [WAYS];
    logic [31:0]          w_cache_rdata;
    logic                 w_hit, w_start, w_data_we, w_fill_done;
    logic                 w_inval_fill, w_killed, w_victim;
    logic [WORD_BITS-1:0] w_wr_word;

    assign w_hit        = rreq && (|w_way_hit);
    assign w_start      = (r_state == c_IDLE) && rreq && peek_miss && !w_hit;
    assign w_data_we    = ((r_state == c_WAIT) && !l2_busy) || (r_state == c_FILL);
    assign w_wr_word    = (r_state == c_WAIT) ? '0 : r_word_cnt;
    assign w_fill_done  = (r_state == c_FILL) && (r_word_cnt == c_LAST_WORD);
    assign w_inval_fill = invalid_req && (r_state != c_IDLE) &&
                          (w_inv_tag == r_fill_tag) && (w_inv_set == r_fill_set);
    assign w_killed     = r_kill || w_inval_fill || flush_req;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            icache_way #(
                .SET_BITS  (SET_BITS),
                .WORD_BITS (WORD_BITS),
                .TAG_BITS  (TAG_BITS)
            ) u_way (
                .clk       (clk),
                .reset     (reset),
                .rd_set    (w_set),
                .rd_word   (w_word),
                .rd_tag    (w_tag),
                .hit       (w_way_hit[g]),
                .rdata     (w_way_rdata[g]),
                .set_valid (w_way_valid[g]),
                .tag_we    ((r_state == c_REQ) && (r_victim == 1'(g))),
                .wr_set    (r_fill_set),
                .wr_tag    (r_fill_tag),
                .data_we   (w_data_we && (r_victim == 1'(g))),
                .wr_word   (w_wr_word),
                .wr_data   (l2_rdata),
                .valid_we  (w_fill_done && !w_killed && (r_victim == 1'(g))),
                .inval_req (invalid_req),
                .inval_set (w_inv_set),
                .inval_tag (w_inv_tag),
                .flush     (flush_req)
            );
        end

        if (WAYS == ICACHE_MAX_WAYS) begin : g_lru
            logic [(1<<SET_BITS)-1:0] r_lru;

            // LRU bit names the way to evict next in that set.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_lru <= '0;
                end else begin
                    if ((r_state == c_IDLE) && w_hit)
                        r_lru[w_set] <= ~w_way_hit[1];
                    if (w_fill_done && !w_killed)
                        r_lru[r_fill_set] <= ~r_victim;
                end
            end

            assign w_victim = !w_way_valid[0] ? 1'b0 :
                              !w_way_valid[1] ? 1'b1 : r_lru[w_set];
        end else begin : g_no_lru
            assign w_victim = 1'b0;
        end
    endgenerate

    always_comb begin
        w_cache_rdata = 32'h0;
        for (int i = 0; i < WAYS; i++)
            w_cache_rdata = w_cache_rdata | w_way_rdata[i];
    end

    assign rdata     = peek_miss ? w_cache_rdata : peek_rdata;
    assign miss      = rreq && ((peek_miss && !w_hit) || (r_state != c_IDLE));
    assign peek_addr = addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_next = c_REQ;
            c_REQ:   w_next = c_WAIT;
            c_WAIT:  if (!l2_busy) w_next = c_FILL;
            c_FILL:  if (r_word_cnt == c_LAST_WORD) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2_rreq       <= 1'b0;
            l2_addr       <= 32'h0;
            l2_burst_size <= 5'd0;
            hit_count     <= 32'h0;
            r_fill_tag    <= '0;
            r_fill_set    <= '0;
            r_victim      <= 1'b0;
            r_word_cnt    <= '0;
            r_kill        <= 1'b0;
        end else begin
            l2_rreq <= w_start;
            if (w_start) begin
                r_fill_tag    <= w_tag;
                r_fill_set    <= w_set;
                r_victim      <= w_victim;
                l2_addr       <= {addr[31:c_OFF_BITS], {c_OFF_BITS{1'b0}}};
                l2_burst_size <= 5'(c_LINE_WORDS);
                r_kill        <= 1'b0;
            end else if ((r_state != c_IDLE) && (w_inval_fill || flush_req)) begin
                r_kill <= 1'b1;
            end
            if ((r_state == c_IDLE) && w_hit)
                hit_count <= hit_count + 32'd1;
            if (r_state == c_WAIT)
                r_word_cnt <= WORD_BITS'(1);
            else if (r_state == c_FILL)
                r_word_cnt <= r_word_cnt + WORD_BITS'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_icache_assoc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_l1_icache_assoc                                               |
// | Directed vector table plus hand sequences for fills and resets.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_l1_icache_assoc;

    logic        clk = 1'b0;
    logic        reset;
    logic        rreq;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        miss;
    logic        l2_rreq;
    logic [31:0] l2_addr;
    logic [4:0]  l2_burst_size;
    logic [31:0] l2_rdata;
    logic        l2_busy;
    logic [31:0] peek_addr;
    logic [31:0] peek_rdata;
    logic        peek_miss;
    logic        invalid_req;
    logic [26:0] invalid_line;
    logic        flush_req;
    logic [31:0] hit_count;

    l1_icache_assoc #(.SET_BITS(4), .WORD_BITS(3), .WAYS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .rreq          (rreq),
        .addr          (addr),
        .rdata         (rdata),
        .miss          (miss),
        .l2_rreq       (l2_rreq),
        .l2_addr       (l2_addr),
        .l2_burst_size (l2_burst_size),
        .l2_rdata      (l2_rdata),
        .l2_busy       (l2_busy),
        .peek_addr     (peek_addr),
        .peek_rdata    (peek_rdata),
        .peek_miss     (peek_miss),
        .invalid_req   (invalid_req),
        .invalid_line  (invalid_line),
        .flush_req     (flush_req),
        .hit_count     (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic        pm;
        logic [31:0] prd;
        logic        exp_miss;
        logic [31:0] exp_rdata;
        logic        hit_inc;
    } vec_t;

    vec_t        vq[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          pulses     = 0;
    int          exp_pulses = 0;
    logic [31:0] exp_hits   = 0;

    always @(negedge clk) if (l2_rreq) pulses++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [31:0] a, input logic pm, input logic [31:0] prd,
                                input logic em, input logic [31:0] erd, input logic hi);
        vec_t v;
        v.id = vq.size(); v.a = a; v.pm = pm; v.prd = prd;
        v.exp_miss = em; v.exp_rdata = erd; v.hit_inc = hi;
        vq.push_back(v);
    endfunction

    // Misses are probed combinationally and rreq is dropped before the edge so no fill starts.
    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        rreq = 1'b1; addr = v.a; peek_miss = v.pm; peek_rdata = v.prd;
        #1;
        chk($sformatf("vec%0d miss", v.id), {31'h0, miss}, {31'h0, v.exp_miss});
        chk($sformatf("vec%0d rdata", v.id), rdata, v.exp_rdata);
        if (v.exp_miss) rreq = 1'b0;
        @(posedge clk); #1;
        rreq = 1'b0; peek_miss = 1'b1;
        exp_hits = exp_hits + {31'h0, v.hit_inc};
        chk($sformatf("vec%0d hit_count", v.id), hit_count, exp_hits);
        chk($sformatf("vec%0d l2_rreq", v.id), {31'h0, l2_rreq}, 32'h0);
    endtask

    task automatic run_vecs(input int n);
        for (int i = 0; i < n; i++) apply_vec(vq.pop_front());
    endtask

    task automatic do_fill(input logic [31:0] a, input logic [31:0] base,
                           input int busy_n, input int kill_word, input string nm);
        logic [31:0] line;
        line = {a[31:5], 5'b0};
        exp_pulses++;
        @(negedge clk);
        rreq = 1'b1; addr = a; peek_miss = 1'b1; l2_busy = 1'b1;
        #1 chk({nm, " miss_idle"}, {31'h0, miss}, 32'h1);
        @(posedge clk); #1;
        chk({nm, " l2_rreq"}, {31'h0, l2_rreq}, 32'h1);
        chk({nm, " l2_addr"}, l2_addr, line);
        chk({nm, " l2_burst_size"}, {27'h0, l2_burst_size}, 32'd8);
        @(negedge clk);
        addr = 32'h0000_7ffc;
        #1 chk({nm, " miss_req"}, {31'h0, miss}, 32'h1);
        @(posedge clk); #1;
        chk({nm, " l2_rreq_low"}, {31'h0, l2_rreq}, 32'h0);
        for (int i = 0; i < busy_n; i++) begin
            @(negedge clk);
            l2_busy = 1'b1; l2_rdata = 32'hBAD0_0000 + i;
            @(posedge clk);
        end
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            l2_busy = 1'b0; l2_rdata = base + w;
            invalid_req = (w == kill_word); invalid_line = line[31:5];
            if (w == 7) addr = a;
            #1 chk($sformatf("%s miss_fill%0d", nm, w), {31'h0, miss}, 32'h1);
            @(posedge clk);
        end
        #1;
        rreq = 1'b0; invalid_req = 1'b0; l2_busy = 1'b1;
    endtask

    task automatic pulse_inval(input logic [26:0] ln);
        @(negedge clk);
        invalid_req = 1'b1; invalid_line = ln;
        @(posedge clk); #1 invalid_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rreq = 1'b0; addr = 32'h0; peek_miss = 1'b1; peek_rdata = 32'h0;
        l2_rdata = 32'h0; l2_busy = 1'b1; invalid_req = 1'b0; invalid_line = '0; flush_req = 1'b0;

        // Vector table, consumed in segments between hand-written sequences.
        add(32'h1044, 1, 0, 0, 32'hA1, 1);           // 0  first hit after cold fill
        add(32'h1244, 1, 0, 0, 32'hB1, 1);           // 1
        add(32'h125C, 1, 0, 0, 32'hB7, 1);           // 2
        add(32'h105C, 1, 0, 0, 32'hA7, 1);           // 3
        add(32'h2000, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0); // 4 peek hit
        add(32'h1440, 1, 0, 1, 32'h0, 0);            // 5
        add(32'h1040, 1, 0, 0, 32'hA0, 1);           // 6
        add(32'h1444, 1, 0, 0, 32'hC1, 1);           // 7  C landed in way1
        add(32'h1244, 1, 0, 1, 32'h0, 0);            // 8  B evicted
        add(32'h1040, 1, 0, 0, 32'hA0, 1);           // 9
        add(32'h1040, 1, 0, 0, 32'hA0, 1);           // 10 after D fill
        add(32'h1444, 1, 0, 1, 32'h0, 0);            // 11 C evicted by D
        add(32'h1248, 1, 0, 0, 32'hD2, 1);           // 12
        add(32'h1044, 1, 0, 1, 32'h0, 0);            // 13 after invalidate
        add(32'h1044, 1, 0, 0, 32'hE1, 1);           // 14
        add(32'h1248, 1, 0, 0, 32'hD2, 1);           // 15
        add(32'h1044, 1, 0, 1, 32'h0, 0);            // 16 before killed fill
        add(32'h1044, 1, 0, 0, 32'h51, 1);           // 17
        add(32'h124C, 1, 0, 0, 32'hD3, 1);           // 18
        add(32'h1144, 1, 0, 1, 32'h0, 0);            // 19 killed at completion
        add(32'h3008, 1, 0, 0, 32'h62, 1);           // 20
        add(32'h3008, 1, 0, 1, 32'h0, 0);            // 21 after flush
        add(32'h1044, 1, 0, 1, 32'h0, 0);            // 22
        add(32'h1248, 1, 0, 1, 32'h0, 0);            // 23
        add(32'h1044, 1, 0, 1, 32'h0, 0);            // 24 after reset
        add(32'h3008, 1, 0, 1, 32'h0, 0);            // 25
        add(32'h1248, 1, 0, 0, 32'h72, 1);           // 26

        repeat (2) @(negedge clk);
        #1;
        chk("reset l2_rreq", {31'h0, l2_rreq}, 32'h0);
        chk("reset l2_addr", l2_addr, 32'h0);
        chk("reset l2_burst_size", {27'h0, l2_burst_size}, 32'h0);
        chk("reset hit_count", hit_count, 32'h0);
        chk("reset miss", {31'h0, miss}, 32'h0);
        reset = 1'b0;

        do_fill(32'h1044, 32'hA0, 2, -1, "fillA");
        chk("fillA pulses", pulses, 1);
        run_vecs(1);
        do_fill(32'h1240, 32'hB0, 0, -1, "fillB");
        run_vecs(6);
        do_fill(32'h1440, 32'hC0, 1, -1, "fillC");
        run_vecs(3);
        do_fill(32'h1240, 32'hD0, 0, -1, "fillD");
        run_vecs(3);

        pulse_inval({23'h8, 4'h2});
        run_vecs(1);
        do_fill(32'h1044, 32'hE0, 1, -1, "fillE");
        run_vecs(2);

        pulse_inval({23'h8, 4'h2});
        run_vecs(1);
        do_fill(32'h1044, 32'hF0, 1, 3, "fillKill");
        do_fill(32'h1044, 32'h50, 0, -1, "refill");
        run_vecs(2);
        do_fill(32'h1144, 32'h80, 0, 7, "fillKillLast");
        run_vecs(1);

        do_fill(32'h3004, 32'h60, 0, -1, "fill3000");
        run_vecs(1);
        @(negedge clk); flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        run_vecs(3);

        // Reset in the middle of a burst.
        exp_pulses++;
        @(negedge clk); rreq = 1'b1; addr = 32'h3004; peek_miss = 1'b1; l2_busy = 1'b1;
        @(posedge clk); #1 rreq = 1'b0;
        @(negedge clk); l2_busy = 1'b0; l2_rdata = 32'h99;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset l2_rreq", {31'h0, l2_rreq}, 32'h0);
        chk("midreset l2_addr", l2_addr, 32'h0);
        chk("midreset l2_burst_size", {27'h0, l2_burst_size}, 32'h0);
        chk("midreset hit_count", hit_count, 32'h0);
        rreq = 1'b1; peek_miss = 1'b0;
        #1 chk("midreset idle", {31'h0, miss}, 32'h0);
        rreq = 1'b0; peek_miss = 1'b1; l2_busy = 1'b1;
        exp_hits = 32'h0;
        @(negedge clk); reset = 1'b0;
        run_vecs(2);
        do_fill(32'h1248, 32'h70, 1, -1, "fillAfterReset");
        run_vecs(1);

        chk("total l2 pulses", pulses, exp_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l1_icache_assoc.md
Name: l1_icache_assoc

Overview:
- Parametrised successor to the direct-mapped L1 instruction cache: configurable sets, line length and 1- or 2-way associativity with per-set LRU replacement.
- Sits between the fetch stage and the shared L2 port. It peeks into the DCache first and fills lines from L2 by burst read.
- Adds flush-all, invalidate-during-fill protection and a hit counter for performance monitoring.

Parameters:
- SET_BITS, 4, log2 number of sets (1..8)
- WORD_BITS, 3, log2 words per line (1..4); LINE_WORDS = 2**WORD_BITS
- WAYS, 2, associativity, 1 or 2 only
- TAG_BITS, 32-SET_BITS-WORD_BITS-2, derived, not overridable

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rreq  in  1  fetch read request
- addr  in  32  fetch byte address (word aligned)
- rdata  out  32  fetch data, combinational
- miss  out  1  fetch must stall this cycle
- l2_rreq  out  1  one-cycle burst request pulse
- l2_addr  out  32  line-aligned burst address
- l2_burst_size  out  5  words in burst (= LINE_WORDS)
- l2_rdata  in  32  burst data
- l2_busy  in  1  L2 not yet streaming
- peek_addr  out  32  = addr
- peek_rdata  in  32  DCache data
- peek_miss  in  1  DCache does not hold addr
- invalid_req  in  1  invalidate one line
- invalid_line  in  TAG_BITS+SET_BITS  {tag,set} to invalidate
- flush_req  in  1  invalidate all lines
- hit_count  out  32  wrapping count of cache hits

Behaviour:
- Address split: {tag, set, word, 2'b00}.
- Reset (async) clears:
  - state=IDLE, all valid bits 0, all LRU bits 0
  - l2_rreq=0, l2_addr=0, l2_burst_size=0, hit_count=0
  - Tag and data arrays are not reset.
- Hit: rreq and some way w has valid[w][set] and tag[w][set]==tag. Hit ways are mutually exclusive by construction. rdata = that way's word, else 0 when no way hits.
- Output muxing: rdata = peek_miss ? cache_rdata : peek_rdata. miss = rreq & ((peek_miss & ~hit) | state!=IDLE).
- Zero-latency hit: miss=0 in the same cycle. On a hit in IDLE, LRU[set] is set to point at the other way (WAYS=2) and hit_count increments. DCache peek hits do not count.
- States: IDLE, REQ, WAIT, FILL.
  - IDLE -> REQ when rreq & peek_miss & ~hit. Latch fill_tag/fill_set from addr and choose victim: first invalid way (way0 priority), else LRU[set]. Drive l2_rreq=1, l2_addr={tag,set,0}, l2_burst_size=LINE_WORDS.
  - REQ -> WAIT after one cycle. l2_rreq returns to 0; write fill_tag into the victim's tag entry and clear its valid bit.
  - WAIT -> FILL on the first cycle l2_busy=0. That cycle's l2_rdata is word 0 and is written.
  - FILL: one word per cycle, words 1..LINE_WORDS-1 in order. After writing the last word, return to IDLE.
  - Fill completion sets valid and sets LRU[set] = other way, unless the line was killed during the fill (see below).
  - The request is re-evaluated in IDLE and hits the next cycle.
- addr may change during a fill; the fill uses only latched values.
- Invalidation:
  - invalid_req clears valid for any way whose {tag,set} matches, in any state.
  - If the match is the line being filled, a kill flag is set and completion leaves it invalid.
  - If invalidate and fill completion hit the same line in the same cycle, invalidate wins.
- flush_req clears every valid bit next cycle and sets the kill flag if a fill is in progress. An in-flight L2 burst is still consumed to keep the L2 protocol aligned.
- WAYS=1: LRU logic is omitted and the victim is always way 0.
- hit_count wraps at 2^32.

Decomposition:
- Shared package icache_pkg:
  - state encoding localparams (IDLE/REQ/WAIT/FILL)
  - address-field width functions
  - ICACHE_MAX_WAYS=2
- One sub-module, icache_way: tag array, valid array, data array for one way. Provides combinational hit/rdata and single-word write port; instantiated WAYS times via generate.

Test Plan (defaults SET_BITS=4, WORD_BITS=3, WAYS=2):
- Cold miss, rreq addr=0x1044, peek_miss=1, L2 streams 0xA0..0xA7 after 2 busy cycles:
  - l2_rreq pulses once with l2_addr=0x1040, l2_burst_size=8.
  - miss=1 throughout; first IDLE cycle after fill gives miss=0, rdata=0xA1, hit_count=1.
- Fill 0x1040 (way0) then 0x1240 (way1, set 2), re-read 0x1040, then miss 0x1440:
  - Victim is way1; 0x1240 then misses; 0x1040 still hits.
- invalid_req with invalid_line={23'h8,4'h2} after 0x1040 resident -> read 0x1044 misses, new burst at 0x1040.
- invalid_req for 0x1040 during its FILL -> fill completes and 8 words are consumed, but the next read of 0x1044 misses again.
- peek_miss=0, peek_rdata=0xDEADBEEF, rreq addr=0x2000 -> miss=0, rdata=0xDEADBEEF, no l2_rreq, hit_count unchanged.
- flush_req with 3 lines resident, then reset asserted mid-fill:
  - After the flush, all reads miss.
  - After reset: l2_rreq=0, state IDLE, hit_count=0, no stale valid lines.
